fp_align_pipe: RTL
==================

# fp_align_pipe

Parametrised, two-stage pipelined operand aligner for the floating-point adder. It takes two unpacked IEEE-style operands plus an add/sub opcode. It orders them by magnitude, handles denormals, right-shifts the smaller mantissa with guard/round/sticky collection, and applies two's-complement negation for effective subtraction. Output feeds the mantissa adder/normaliser through a valid/ready handshake.

## Interface
Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width (no hidden bit)
- Derived W = MAN_W+6: [W-1] sign, [W-2] carry headroom, [W-3] hidden bit, [W-4:3] fraction, [2] guard, [1] round, [0] sticky

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input operand pair valid
- in_ready  out  1  pipeline accepts input this cycle
- sub  in  1  1 = A−B, 0 = A+B
- sign_a, sign_b  in  1 each  operand signs
- exp_a, exp_b  in  EXP_W each  biased exponents
- man_a, man_b  in  MAN_W each  fractions
- out_valid  out  1  output valid
- out_ready  in  1  downstream accepts
- exp_out  out  EXP_W  effective exponent of the larger operand
- res_sign  out  1  sign of the result
- eff_sub  out  1  effective subtraction flag
- big_m  out  W  aligned larger mantissa, always non-negative
- small_m  out  W  aligned smaller mantissa, two's complement, negated when eff_sub

## Operation
- Effective sign of B: sb = sign_b ^ sub. eff_sub = sign_a ^ sb.
- Denormal: exponent 0 means hidden bit 0 and effective exponent 1. Otherwise hidden bit 1 and effective exponent equals the exponent field.
- Stage 1 (compare/swap) registers the following:
  - A is big if ea > eb, or if ea == eb and {hidden_a, man_a} >= {hidden_b, man_b}. Ties go to A.
  - Otherwise B is big.
  - d = e_big − e_small, unsigned, EXP_W bits.
  - The big/small mantissas are {2'b00, hidden, man, 3'b000}.
  - res_sign is sign_a if A is big, else sb.
  - Exact cancellation (equal magnitudes, eff_sub) still reports res_sign = sign_a. Sign fixing for zero results is done downstream.
- Stage 2 (shift/negate) registers the following:
  - small is logically right-shifted by d.
  - Sticky bit [0] = OR of the original bit 0 and every bit shifted out.
  - If d >= MAN_W+4, the shifted value is 0 and sticky = 1. The source mantissa is always nonzero in this case, unless both hidden and fraction are 0, in which case sticky = 0.
  - If eff_sub, small_m = (~shifted + 1) mod 2^W.
  - big_m, exp_out, res_sign and eff_sub pass through unchanged.
- No rounding or normalisation in this block.

## Timing
- Latency: 2 cycles from the in_valid&&in_ready edge to out_valid.
- Throughput: 1 pair per cycle while out_ready = 1.
- Handshake, with v1/v2 as the stage valid flags:
  - en2 = ~v2 | out_ready
  - en1 = ~v1 | en2
  - in_ready = en1
  - in_ready depends combinationally on out_ready; this path is allowed.
- Stall: while out_valid && !out_ready, all outputs are held bit-stable and stage 1 holds if full.
- Bubbles collapse: an empty stage 2 accepts from stage 1 regardless of out_ready.
- Simultaneous accept and drain on a full pipe moves all stages forward in the same cycle, with no loss or duplication.
- Reset (rst_n = 0 at a clock edge):
  - v1 = v2 = 0 and out_valid = 0.
  - exp_out, res_sign, eff_sub, big_m and small_m are all 0.
  - in_ready reads 1 from the first cycle after reset.
  - Reset mid-operation discards in-flight pairs.
- Data registers load only on their stage enable with valid input. They are not required to clear on bubbles, except at reset.

## Test plan
Defaults: MAN_W=23, EXP_W=8, W=29.
- 1.0 + 0.5: A=(0,127,0), B=(0,126,0), sub=0 -> after 2 cycles: exp_out=127, big_m=0x4000000, small_m=0x2000000, eff_sub=0, res_sign=0.
- 1.0 − 1.0: A=(0,127,0), B=(0,127,0), sub=1 -> big_m=0x4000000, small_m=0x1C000000, eff_sub=1, res_sign=0.
- Swap and sign: A=(0,100,0), B=(1,127,0), sub=0 -> exp_out=127, big_m=0x4000000, res_sign=1, eff_sub=1, small_m = −(0x4000000>>27 plus sticky) = 0x1FFFFFFF.
- Sticky and overflow shift, with A=(0,127,0), sub=0:
  - B=(0,100,1) -> small_m=0x0000001.
  - B=(0,0,0) with d=126 -> small_m=0x0000000.
- Denormals: A=(0,1,0), B=(0,0,0x400000), sub=0 -> d=0, exp_out=1, big_m=0x4000000, small_m=0x2000000.
- Handshake:
  - Stream 4 pairs with out_ready low for 3 cycles after the first output -> in_ready drops once both stages are full, outputs stay stable during the stall, and all 4 results emerge in order with none lost or duplicated.
  - Assert rst_n=0 mid-stream -> out_valid=0 the next cycle and no stale output afterward.

Source files
------------

// File: rtl/fp_align_pipe.sv
// fp_align_pipe
// Two-stage pipelined operand aligner that sits in front of the floating-point
// adder. Stage 1 orders the operands by magnitude and builds the extended
// mantissas. Stage 2 right-shifts the smaller mantissa, collecting sticky, and
// negates it for effective subtraction.
//
// Extended mantissa layout (W = MAN_W+6):
//   [W-1] sign, [W-2] carry headroom, [W-3] hidden bit, [W-4:3] fraction,
//   [2] guard, [1] round, [0] sticky
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   input operand-pair handshake
//   sub                 1 = A-B, 0 = A+B
//   sign_a/b, exp_a/b,
//   man_a/b             unpacked operands (biased exponent, stored fraction)
//   out_valid/out_ready output handshake
//   exp_out             effective exponent of the larger operand
//   res_sign            sign of the result
//   eff_sub             effective subtraction flag
//   big_m               aligned larger mantissa (non-negative)
//   small_m             aligned smaller mantissa, two's complement
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = MAN_W + 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  logic [MAN_W-1:0] man_a,
  input  logic [MAN_W-1:0] man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp_out,
  output logic             res_sign,
  output logic             eff_sub,
  output logic [W-1:0]     big_m,
  output logic [W-1:0]     small_m
);

  // Shifts of this size or more push every significant bit past the sticky slot.
  localparam logic [31:0] SHIFT_MAX = 32'(MAN_W + 4);
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] W_ONE = {{(W-1){1'b0}}, 1'b1};

  // Stage valid flags and enables
  logic v1, v2;
  logic en1, en2;

  // Stage 1 registers
  logic [EXP_W-1:0] s1_exp;
  logic [EXP_W-1:0] s1_d;
  logic             s1_sign;
  logic             s1_eff;
  logic [W-1:0]     s1_big;
  logic [W-1:0]     s1_small;

  // Stage 1 combinational values
  logic             sb_eff;
  logic             eff_sub_c;
  logic             hid_a, hid_b;
  logic [EXP_W-1:0] ea, eb;
  logic             a_big;
  logic [W-1:0]     ext_a, ext_b;

  // Stage 2 combinational values
  logic [W-1:0]     shifted;
  logic [W-1:0]     aligned;
  logic             lost;

  // A stage may load when it is empty or when its contents move on this cycle,
  // so bubbles collapse and a full pipe advances as one while draining.
  assign en2      = ~v2 | out_ready;
  assign en1      = ~v1 | en2;
  assign in_ready = en1;
  assign out_valid = v2;

  // Operand classification and magnitude ordering. A zero exponent field marks
  // a denormal, which has no hidden bit and behaves as exponent 1. Equal
  // magnitudes keep A as the larger operand.
  always_comb begin
    sb_eff    = sign_b ^ sub;
    eff_sub_c = sign_a ^ sb_eff;
    hid_a     = |exp_a;
    hid_b     = |exp_b;
    ea        = hid_a ? exp_a : EXP_ONE;
    eb        = hid_b ? exp_b : EXP_ONE;
    ext_a     = {2'b00, hid_a, man_a, 3'b000};
    ext_b     = {2'b00, hid_b, man_b, 3'b000};
    a_big     = (ea > eb) || ((ea == eb) && ({hid_a, man_a} >= {hid_b, man_b}));
  end

  // Stage 1 register: captures the ordered operands, exponent difference and
  // result sign whenever a new pair is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1       <= 1'b0;
      s1_exp   <= '0;
      s1_d     <= '0;
      s1_sign  <= 1'b0;
      s1_eff   <= 1'b0;
      s1_big   <= '0;
      s1_small <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_eff <= eff_sub_c;
        if (a_big) begin
          s1_exp   <= ea;
          s1_d     <= ea - eb;
          s1_sign  <= sign_a;
          s1_big   <= ext_a;
          s1_small <= ext_b;
        end else begin
          s1_exp   <= eb;
          s1_d     <= eb - ea;
          s1_sign  <= sb_eff;
          s1_big   <= ext_b;
          s1_small <= ext_a;
        end
      end
    end
  end

  // Alignment shift. Everything that falls off the bottom, together with the
  // bit landing in position 0, folds into the sticky bit. Very large shifts
  // leave only sticky, which is set if any mantissa bit was present.
  always_comb begin
    shifted = '0;
    lost    = 1'b0;
    if (32'(s1_d) >= SHIFT_MAX) begin
      shifted = '0;
      lost    = |s1_small;
    end else begin
      shifted = s1_small >> s1_d;
      lost    = |(s1_small & ~({W{1'b1}} << s1_d));
    end
    aligned = {shifted[W-1:1], shifted[0] | lost};
    if (s1_eff) begin
      aligned = ~aligned + W_ONE;
    end
  end

  // Stage 2 register: drives the outputs directly, so holding it while the
  // consumer stalls keeps every output bit-stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2       <= 1'b0;
      exp_out  <= '0;
      res_sign <= 1'b0;
      eff_sub  <= 1'b0;
      big_m    <= '0;
      small_m  <= '0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        exp_out  <= s1_exp;
        res_sign <= s1_sign;
        eff_sub  <= s1_eff;
        big_m    <= s1_big;
        small_m  <= aligned;
      end
    end
  end

endmodule
